unidade_pc: RTL and testbench
=============================

# unidade_pc

Program-counter unit of the processor: holds the architectural PC and selects the next address from PC+4, the branch target, the jump target produced by the jump adder, or a register value for jump-register. It also gates PC advance with a stall enable, supports a halt request, and traps word-misaligned targets. It sits at the head of the fetch path, feeding the instruction memory and the PC-relative adders, including the jump adder.

## Interface
- ENDERECO_INICIAL, 32'h0000_0000, PC value loaded on reset; must be a multiple of 4, checked at elaboration.

- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- habilita  in  1  1 = PC may advance this cycle; 0 = stall, hold PC
- sel_proximo  in  2  next-PC source: 00 PC+4, 01 branch, 10 jump, 11 jump-register
- endereco_branch  in  32  branch target
- endereco_jump  in  32  jump target (PC + shifted address)
- endereco_registrador  in  32  jump-register target
- halt  in  1  stop request
- endereco_PC  out  32  current PC, registered
- endereco_PC_mais4  out  32  endereco_PC + 4, combinational from the register
- executando  out  1  1 while in state EXECUTANDO
- excecao  out  1  sticky misaligned-target flag, registered
- endereco_invalido  out  32  captured offending target, registered

## Operation
- **States:**
  - INICIO: entered on reset.
  - EXECUTANDO: normal advance.
  - PARADO: halted, sticky.
  - ERRO: misaligned trap, sticky.
- **Reset** (reset=0 at a rising edge):
  - endereco_PC=ENDERECO_INICIAL, state=INICIO.
  - excecao=0, endereco_invalido=0, executando=0.
  - Reset overrides every other input in every state, including mid-stall, PARADO and ERRO.
- **INICIO:** PC held. Next cycle always goes to EXECUTANDO. halt, habilita and sel_proximo are ignored in this state.
- **EXECUTANDO**, evaluated in priority order:
  - halt=1: PC held, go to PARADO. This applies regardless of habilita.
  - habilita=0: PC held, stay in EXECUTANDO.
  - Selected target has [1:0]≠0: PC held, endereco_invalido=target, excecao=1, go to ERRO.
  - Otherwise: endereco_PC=selected target.
- **PARADO and ERRO:** PC and all captured outputs are frozen. Only reset exits these states.
- **Arithmetic:**
  - PC+4 is computed modulo 2^32, so 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
  - sel 00 can never trap, because the PC is always word-aligned.
- Targets are not range-checked. Only bits [1:0] are examined.

## Timing
- Single clock. All state and outputs update on the rising edge of clock.
- endereco_PC_mais4 is the only combinational output; it follows endereco_PC within the same cycle.
- **Latency:** a target presented in cycle n with habilita=1 appears on endereco_PC in cycle n+1.
- **Reset release:** the first advance happens on the second rising edge after reset returns to 1. INICIO lasts exactly one cycle.
- executando goes high one cycle after reset is released. It goes low in the cycle after halt or a trap is sampled.
- **Simultaneous halt and misaligned target:** halt wins and excecao stays 0.
- **Simultaneous habilita=0 and misaligned target:** no trap. The target is not evaluated while stalled.

## Structure
- Package pc_pkg holds:
  - localparams SEL_PC4, SEL_BRANCH, SEL_JUMP, SEL_JR (2-bit).
  - The state encoding INICIO, EXECUTANDO, PARADO, ERRO (2-bit).
- One natural sub-module: somador_PC_4, a pure 32-bit +4 adder that drives endereco_PC_mais4 and the sel 00 path.
- The next-PC mux, alignment check, FSM and registers live in unidade_pc.

## Test plan
- **Reset and advance:** reset low 2 cycles, then high; sel=00, habilita=1 → PC=0 for 2 cycles after release, then 4, 8, 12; executando=1 from cycle 1 after release.
- **Stall and jump:** at PC=8, habilita=0 for 3 cycles with sel=10, endereco_jump=0x40 → PC stays 8. habilita=1 → next cycle PC=0x40, endereco_PC_mais4=0x44.
- **Misaligned branch:** sel=01, endereco_branch=0x102 → PC held, excecao=1, endereco_invalido=0x102, executando=0. Later aligned targets and halt are ignored until reset, after which excecao=0.
- **Halt priority:** halt=1 together with sel=11, endereco_registrador=0x7 → state PARADO, excecao=0, PC unchanged. Reset mid-halt → PC=ENDERECO_INICIAL.
- **Wrap-around:** jump to 0xFFFF_FFFC, then sel=00 → PC=0x0000_0000, no exception.
- **Parameter override:** ENDERECO_INICIAL=0x0040_0000 → PC after reset is 0x0040_0000; first advance gives 0x0040_0004.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC source
// selector codes and the control state encoding.
package pc_pkg;

  // Next-PC source selector codes (sel_proximo)
  localparam logic [1:0] SEL_PC4    = 2'b00;
  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_JUMP   = 2'b10;
  localparam logic [1:0] SEL_JR     = 2'b11;

  // Number of next-PC sources
  localparam int unsigned NUM_FONTES = 4;

  // Control states of the PC unit
  typedef enum logic [1:0] {
    INICIO     = 2'b00,
    EXECUTANDO = 2'b01,
    PARADO     = 2'b10,
    ERRO       = 2'b11
  } estado_t;

  // A fetch address is usable only when it is word aligned
  function automatic logic alinhado_palavra(input logic [31:0] endereco);
    return (endereco[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/unidade_pc_somador_PC_4.sv
// Pure 32-bit +4 adder; wraps modulo 2^32 with no carry out.
module somador_PC_4 (
  input  logic [31:0] entrada,
  output logic [31:0] soma
);

  assign soma = entrada + 32'd4;

endmodule

// File: rtl/unidade_pc.sv
// Program-counter unit: holds the PC, selects the next fetch address,
// gates advance with a stall enable, and parks in a sticky state on
// halt or on a word-misaligned target.
module unidade_pc
  import pc_pkg::*;
#(
  parameter logic [31:0] ENDERECO_INICIAL = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        habilita,
  input  logic [1:0]  sel_proximo,
  input  logic [31:0] endereco_branch,
  input  logic [31:0] endereco_jump,
  input  logic [31:0] endereco_registrador,
  input  logic        halt,
  output logic [31:0] endereco_PC,
  output logic [31:0] endereco_PC_mais4,
  output logic        executando,
  output logic        excecao,
  output logic [31:0] endereco_invalido
);

  // The reset address must itself be fetchable
  generate
    if (ENDERECO_INICIAL[1:0] != 2'b00) begin : g_check_inicial
      $error("unidade_pc: ENDERECO_INICIAL must be a multiple of 4");
    end
  endgenerate

  estado_t     estado_reg;
  logic [31:0] pc_reg;
  logic        executando_reg;
  logic        excecao_reg;
  logic [31:0] invalido_reg;

  logic [31:0] pc_mais4;
  logic [31:0] fontes [NUM_FONTES];
  logic [NUM_FONTES-1:0] fonte_alinhada;
  logic [31:0] pc_next;
  logic        alvo_desalinhado;

  somador_PC_4 u_somador (
    .entrada (pc_reg),
    .soma    (pc_mais4)
  );

  // Gather candidate next addresses indexed by the selector code
  always_comb begin
    fontes[SEL_PC4]    = pc_mais4;
    fontes[SEL_BRANCH] = endereco_branch;
    fontes[SEL_JUMP]   = endereco_jump;
    fontes[SEL_JR]     = endereco_registrador;
  end

  // Per-source alignment flags; only the low two bits matter
  genvar gi;
  generate
    for (gi = 0; gi < NUM_FONTES; gi++) begin : g_alinhamento
      assign fonte_alinhada[gi] = alinhado_palavra(fontes[gi]);
    end
  endgenerate

  // Select the next address and whether it would trap
  always_comb begin
    pc_next          = fontes[sel_proximo];
    alvo_desalinhado = ~fonte_alinhada[sel_proximo];
  end

  // Control FSM with PC and captured-status registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_reg     <= INICIO;
      pc_reg         <= ENDERECO_INICIAL;
      executando_reg <= 1'b0;
      excecao_reg    <= 1'b0;
      invalido_reg   <= 32'h0000_0000;
    end else begin
      case (estado_reg)
        INICIO: begin
          // One settling cycle: inputs ignored, PC held
          estado_reg     <= EXECUTANDO;
          executando_reg <= 1'b1;
        end
        EXECUTANDO: begin
          if (halt) begin
            // Halt beats both stall and a simultaneous bad target
            estado_reg     <= PARADO;
            executando_reg <= 1'b0;
          end else if (habilita) begin
            if (alvo_desalinhado) begin
              estado_reg     <= ERRO;
              executando_reg <= 1'b0;
              excecao_reg    <= 1'b1;
              invalido_reg   <= pc_next;
            end else begin
              pc_reg <= pc_next;
            end
          end
        end
        default: begin
          // PARADO and ERRO are sticky until reset
          estado_reg <= estado_reg;
        end
      endcase
    end
  end

  assign endereco_PC       = pc_reg;
  assign endereco_PC_mais4 = pc_mais4;
  assign executando        = executando_reg;
  assign excecao           = excecao_reg;
  assign endereco_invalido = invalido_reg;

endmodule

// File: tb/tb_unidade_pc.sv
// Directed bench for unidade_pc: a default instance plus one with a
// relocated reset address, both driven by the same stimulus.
module tb_unidade_pc;

  logic        clock = 1'b0;
  logic        reset;
  logic        habilita;
  logic [1:0]  sel_proximo;
  logic [31:0] endereco_branch;
  logic [31:0] endereco_jump;
  logic [31:0] endereco_registrador;
  logic        halt;

  logic [31:0] pc_a, mais4_a, inval_a;
  logic        exec_a, exc_a;
  logic [31:0] pc_b, mais4_b, inval_b;
  logic        exec_b, exc_b;

  int checks = 0;
  int passed = 0;

  always #5 clock = ~clock;

  unidade_pc u_dut (
    .clock                (clock),
    .reset                (reset),
    .habilita             (habilita),
    .sel_proximo          (sel_proximo),
    .endereco_branch      (endereco_branch),
    .endereco_jump        (endereco_jump),
    .endereco_registrador (endereco_registrador),
    .halt                 (halt),
    .endereco_PC          (pc_a),
    .endereco_PC_mais4    (mais4_a),
    .executando           (exec_a),
    .excecao              (exc_a),
    .endereco_invalido    (inval_a)
  );

  unidade_pc #(.ENDERECO_INICIAL(32'h0040_0000)) u_dut_reloc (
    .clock                (clock),
    .reset                (reset),
    .habilita             (habilita),
    .sel_proximo          (sel_proximo),
    .endereco_branch      (endereco_branch),
    .endereco_jump        (endereco_jump),
    .endereco_registrador (endereco_registrador),
    .halt                 (halt),
    .endereco_PC          (pc_b),
    .endereco_PC_mais4    (mais4_b),
    .executando           (exec_b),
    .excecao              (exc_b),
    .endereco_invalido    (inval_b)
  );

  // Advance one rising edge and settle before sampling
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
      $display("check %-22s obs=%08h exp=%08h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; habilita = 1'b1; sel_proximo = 2'b00; halt = 1'b0;
    endereco_branch = '0; endereco_jump = '0; endereco_registrador = '0;

    // Reset held for two cycles
    tick(); tick();
    check("rst_pc",      pc_a,    32'h0);
    check("rst_exec",    {31'b0, exec_a}, 32'h0);
    check("rst_exc",     {31'b0, exc_a},  32'h0);
    check("rst_inval",   inval_a, 32'h0);
    check("rst_pc_reloc", pc_b,   32'h0040_0000);

    // Release: INICIO lasts one cycle, then advance by 4
    reset = 1'b1;
    tick();
    check("inicio_pc",   pc_a,    32'h0);
    check("inicio_exec", {31'b0, exec_a}, 32'h1);
    tick();
    check("adv_pc4",     pc_a,    32'h4);
    check("adv_reloc",   pc_b,    32'h0040_0004);
    tick();
    check("adv_pc8",     pc_a,    32'h8);
    check("adv_mais4",   mais4_a, 32'hC);

    // Stall three cycles with a pending jump
    habilita = 1'b0; sel_proximo = 2'b10; endereco_jump = 32'h40;
    tick(); tick(); tick();
    check("stall_pc",    pc_a,    32'h8);
    habilita = 1'b1;
    tick();
    check("jump_pc",     pc_a,    32'h40);
    check("jump_mais4",  mais4_a, 32'h44);

    // Misaligned branch while stalled: not evaluated
    habilita = 1'b0; sel_proximo = 2'b01; endereco_branch = 32'h102;
    tick();
    check("stall_noexc", {31'b0, exc_a}, 32'h0);
    // Now enabled: trap
    habilita = 1'b1;
    tick();
    check("trap_pc",     pc_a,    32'h40);
    check("trap_exc",    {31'b0, exc_a},  32'h1);
    check("trap_inval",  inval_a, 32'h102);
    check("trap_exec",   {31'b0, exec_a}, 32'h0);
    // Sticky: aligned target and halt ignored
    endereco_branch = 32'h200;
    tick();
    halt = 1'b1;
    tick();
    check("erro_pc",     pc_a,    32'h40);
    check("erro_inval",  inval_a, 32'h102);
    check("erro_exc",    {31'b0, exc_a},  32'h1);
    halt = 1'b0;

    // Reset out of ERRO
    reset = 1'b0; sel_proximo = 2'b00;
    tick();
    check("rst2_exc",    {31'b0, exc_a},  32'h0);
    check("rst2_inval",  inval_a, 32'h0);
    check("rst2_pc",     pc_a,    32'h0);
    reset = 1'b1;
    tick(); tick();
    check("adv2_pc",     pc_a,    32'h4);

    // Halt together with a misaligned jump-register target
    halt = 1'b1; sel_proximo = 2'b11; endereco_registrador = 32'h7;
    tick();
    check("halt_pc",     pc_a,    32'h4);
    check("halt_exc",    {31'b0, exc_a},  32'h0);
    check("halt_exec",   {31'b0, exec_a}, 32'h0);
    halt = 1'b0; sel_proximo = 2'b00;
    tick();
    check("parado_pc",   pc_a,    32'h4);
    reset = 1'b0;
    tick();
    check("rst3_pc",     pc_a,    32'h0);
    check("rst3_reloc",  pc_b,    32'h0040_0000);

    // Wrap-around of PC+4
    reset = 1'b1;
    tick();
    sel_proximo = 2'b10; endereco_jump = 32'hFFFF_FFFC;
    tick();
    check("wrap_pc",     pc_a,    32'hFFFF_FFFC);
    check("wrap_mais4",  mais4_a, 32'h0);
    sel_proximo = 2'b00;
    tick();
    check("wrap_adv",    pc_a,    32'h0);
    check("wrap_noexc",  {31'b0, exc_a},  32'h0);

    // Aligned jump-register target
    sel_proximo = 2'b11; endereco_registrador = 32'h1234;
    tick();
    check("jr_pc",       pc_a,    32'h1234);
    check("jr_exec",     {31'b0, exec_a}, 32'h1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
